// File: rtl/itu_channel_if.sv
// Internal peripheral bus as seen by one ITU channel: byte-addressed,
// big-endian lanes, registered read data.
interface itu_channel_if;
  logic [27:0] A;
  logic [31:0] DI;
  logic [31:0] DO;
  logic [3:0]  BA;
  logic        WE;
  logic        REQ;
  logic        BUSY;
  logic        ACT;

  modport master (output A, DI, BA, WE, REQ, input DO, BUSY, ACT);
  modport slave  (input A, DI, BA, WE, REQ, output DO, BUSY, ACT);
endinterface

// File: rtl/itu_channel.sv
// One SH7034 ITU timer channel: prescaled 16-bit up-counter, GRA/GRB compare,
// overflow, read-then-write-0 flag clearing and level interrupt requests.
module itu_channel #(
  parameter logic [27:0] BASE = 28'h5FFFF04
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          CE_R,
  input  logic          CE_F,
  input  logic          RES_N,
  input  logic          STR,
  itu_channel_if.slave  bus,
  output logic          IMIA_IRQ,
  output logic          IMIB_IRQ,
  output logic          OVI_IRQ
);

  logic [6:0]  tcr;
  logic [5:0]  tior;
  logic [2:0]  tier;
  logic [2:0]  flags;
  logic [2:0]  arm;
  logic [15:0] tcnt;
  logic [15:0] gra;
  logic [15:0] grb;
  logic [2:0]  ps;
  logic [31:0] do_q;

  logic [6:0]  tcr_nxt;
  logic [5:0]  tior_nxt;
  logic [2:0]  tier_nxt;
  logic [2:0]  flags_nxt;
  logic [2:0]  arm_nxt;
  logic [15:0] tcnt_nxt;
  logic [15:0] gra_nxt;
  logic [15:0] grb_nxt;
  logic [2:0]  ps_nxt;
  logic [31:0] do_nxt;
  logic [31:0] rdata;

  logic [25:0] woff;
  logic [1:0]  wsel;
  logic        hit;
  logic        wr_en;
  logic        rd_en;
  logic        wr_tsr;
  logic        rd_tsr;
  logic        tick;
  logic        match_a;
  logic        match_b;
  logic        at_max;
  logic        cclr_hit;
  logic [2:0]  flag_set;
  logic [2:0]  flag_clr;
  logic        unused_addr;

  // TPSC 0..3 divide by 1/2/4/8 off the free prescaler; 4..7 select the
  // external clock pins, which this channel does not have.
  function automatic logic div_ok(input logic [2:0] tpsc, input logic [2:0] cnt);
    case (tpsc)
      3'd0:    return 1'b1;
      3'd1:    return ~cnt[0];
      3'd2:    return cnt[1:0] == 2'b00;
      3'd3:    return cnt == 3'd0;
      default: return 1'b0;
    endcase
  endfunction

  assign woff   = bus.A[27:2] - BASE[27:2];
  assign wsel   = woff[1:0];
  assign hit    = woff < 26'd3;
  assign wr_en  = CE_R & bus.REQ & bus.WE & hit;
  assign rd_en  = CE_F & bus.REQ & ~bus.WE & hit;
  assign wr_tsr = wr_en & (wsel == 2'd0) & bus.BA[0];
  assign rd_tsr = rd_en & (wsel == 2'd0) & bus.BA[0];

  assign bus.ACT  = hit;
  assign bus.BUSY = 1'b0;
  assign bus.DO   = do_q;
  assign unused_addr = ^bus.A[1:0];

  assign IMIA_IRQ = flags[0] & tier[0];
  assign IMIB_IRQ = flags[1] & tier[1];
  assign OVI_IRQ  = flags[2] & tier[2];

  // Compare against pre-edge register values so same-cycle CPU writes
  // to TCNT/GRA/GRB never influence this tick's match.
  assign tick     = CE_R & STR & div_ok(tcr[2:0], ps);
  assign match_a  = tcnt == gra;
  assign match_b  = tcnt == grb;
  assign at_max   = &tcnt;
  assign cclr_hit = ((tcr[6:5] == 2'b01) & match_a) | ((tcr[6:5] == 2'b10) & match_b);
  assign flag_set = {tick & at_max, tick & match_b, tick & match_a};
  assign flag_clr = wr_tsr ? (arm & ~bus.DI[2:0]) : 3'b000;

  always_comb begin
    rdata = 32'h0;
    case (wsel)
      2'd0:    rdata = {1'b1, tcr, 1'b1, tior[5:3], 1'b1, tior[2:0],
                        5'h1F, tier, 5'h1F, flags};
      2'd1:    rdata = {tcnt, gra};
      2'd2:    rdata = {grb, 16'h0};
      default: rdata = 32'h0;
    endcase
  end

  always_comb begin
    tcr_nxt   = tcr;
    tior_nxt  = tior;
    tier_nxt  = tier;
    gra_nxt   = gra;
    grb_nxt   = grb;
    tcnt_nxt  = tcnt;
    ps_nxt    = ps;
    do_nxt    = do_q;
    // A set in the same cycle as an armed write-0 clear must survive.
    flags_nxt = (flags & ~flag_clr) | flag_set;
    arm_nxt   = wr_tsr ? 3'b000 : arm;

    if (rd_tsr) arm_nxt = arm_nxt | flags;
    if (rd_en)  do_nxt  = rdata;
    if (CE_R && STR) ps_nxt = ps + 3'd1;

    if (tick) begin
      if (at_max || cclr_hit) tcnt_nxt = 16'h0;
      else                    tcnt_nxt = tcnt + 16'd1;
    end

    if (wr_en) begin
      case (wsel)
        2'd0: begin
          if (bus.BA[3]) tcr_nxt  = bus.DI[30:24];
          if (bus.BA[2]) tior_nxt = {bus.DI[22:20], bus.DI[18:16]};
          if (bus.BA[1]) tier_nxt = bus.DI[10:8];
        end
        2'd1: begin
          // Any CPU write to TCNT replaces the tick update entirely.
          if (bus.BA[3] || bus.BA[2]) tcnt_nxt = tcnt;
          if (bus.BA[3]) tcnt_nxt[15:8] = bus.DI[31:24];
          if (bus.BA[2]) tcnt_nxt[7:0]  = bus.DI[23:16];
          if (bus.BA[1]) gra_nxt[15:8]  = bus.DI[15:8];
          if (bus.BA[0]) gra_nxt[7:0]   = bus.DI[7:0];
        end
        2'd2: begin
          if (bus.BA[3]) grb_nxt[15:8] = bus.DI[31:24];
          if (bus.BA[2]) grb_nxt[7:0]  = bus.DI[23:16];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tcr   <= 7'h00;
      tior  <= 6'h00;
      tier  <= 3'h0;
      flags <= 3'h0;
      arm   <= 3'h0;
      tcnt  <= 16'h0;
      gra   <= 16'hFFFF;
      grb   <= 16'hFFFF;
      ps    <= 3'h0;
      do_q  <= 32'h0;
    end else if (CE_R && !RES_N) begin
      tcr   <= 7'h00;
      tior  <= 6'h00;
      tier  <= 3'h0;
      flags <= 3'h0;
      arm   <= 3'h0;
      tcnt  <= 16'h0;
      gra   <= 16'hFFFF;
      grb   <= 16'hFFFF;
      ps    <= 3'h0;
      do_q  <= 32'h0;
    end else begin
      tcr   <= tcr_nxt;
      tior  <= tior_nxt;
      tier  <= tier_nxt;
      flags <= flags_nxt;
      arm   <= arm_nxt;
      tcnt  <= tcnt_nxt;
      gra   <= gra_nxt;
      grb   <= grb_nxt;
      ps    <= ps_nxt;
      do_q  <= do_nxt;
    end
  end

endmodule

// File: tb/tb_itu_channel.sv
// Directed bench for itu_channel: register map, counting, prescaler,
// overflow, flag clear protocol and same-cycle priority cases.
module tb_itu_channel;
  localparam logic [27:0] BASE = 28'h5FFFF04;

  logic CLK = 1'b0;
  logic RST_N, CE_R, CE_F, RES_N, STR;
  logic IMIA_IRQ, IMIB_IRQ, OVI_IRQ;
  logic [31:0] d;
  int n_chk = 0;
  int n_fail = 0;

  itu_channel_if bus ();

  itu_channel #(.BASE(BASE)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .RES_N(RES_N),
    .STR(STR), .bus(bus),
    .IMIA_IRQ(IMIA_IRQ), .IMIB_IRQ(IMIB_IRQ), .OVI_IRQ(OVI_IRQ)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.REQ = 1'b0;
    bus.WE  = 1'b0;
  endtask

  task automatic wr(input logic [27:0] a, input logic [3:0] ba, input logic [31:0] v);
    bus.A = a; bus.BA = ba; bus.DI = v; bus.WE = 1'b1; bus.REQ = 1'b1;
    step();
    idle();
  endtask

  task automatic rd(input logic [27:0] a, output logic [31:0] v);
    bus.A = a; bus.BA = 4'hF; bus.WE = 1'b0; bus.REQ = 1'b1;
    step();
    v = bus.DO;
    idle();
  endtask

  task automatic stream(input logic [27:0] a);
    bus.A = a; bus.BA = 4'hF; bus.WE = 1'b0; bus.REQ = 1'b1;
  endtask

  task automatic soft_reset();
    RES_N = 1'b0;
    step();
    RES_N = 1'b1;
  endtask

  logic [15:0] seq1 [5] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0};
  logic [15:0] seq4 [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};

  initial begin
    RST_N = 1'b0; CE_R = 1'b1; CE_F = 1'b1; RES_N = 1'b1; STR = 1'b0;
    bus.A = BASE; bus.DI = 32'h0; bus.BA = 4'h0; idle();
    step(); step();
    check("rst_do", bus.DO, 32'h0);
    check("rst_irq", {29'h0, IMIA_IRQ, IMIB_IRQ, OVI_IRQ}, 32'h0);
    check("busy", {31'h0, bus.BUSY}, 32'h0);
    RST_N = 1'b1;
    rd(BASE, d);     check("rst_w0", d, 32'h8088F8F8);
    rd(BASE + 4, d); check("rst_w1", d, 32'h0000FFFF);
    rd(BASE + 8, d); check("rst_w2", d, 32'hFFFF0000);

    bus.A = BASE + 11; #1 check("act_last", {31'h0, bus.ACT}, 32'h1);
    bus.A = BASE + 12; #1 check("act_past", {31'h0, bus.ACT}, 32'h0);
    bus.A = BASE - 1;  #1 check("act_below", {31'h0, bus.ACT}, 32'h0);

    // GRA=3, clear on GRA match, phi
    wr(BASE + 4, 4'b0011, 32'h0000_0003);
    wr(BASE, 4'b1000, 32'h2000_0000);
    stream(BASE + 4);
    STR = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("cnt_seq", {16'h0, bus.DO[31:16]}, {16'h0, seq1[k]});
    end
    STR = 1'b0;
    idle();
    check("imia_dis", {31'h0, IMIA_IRQ}, 32'h0);
    wr(BASE, 4'b0010, 32'h0000_F900);
    check("imia_en", {31'h0, IMIA_IRQ}, 32'h1);
    wr(BASE, 4'b0001, 32'h0000_00F8);
    check("clr_unarmed", {31'h0, IMIA_IRQ}, 32'h1);
    rd(BASE, d);     check("tsr_f9", d, 32'hA088F9F9);
    wr(BASE, 4'b0001, 32'h0000_00F8);
    check("clr_armed", {31'h0, IMIA_IRQ}, 32'h0);
    rd(BASE, d);     check("tsr_f8", d, 32'hA088F9F8);

    // armed write-0 on the same edge as a new GRA match: set wins
    STR = 1'b1;
    step(); step(); step();
    check("imia_rematch", {31'h0, IMIA_IRQ}, 32'h1);
    rd(BASE, d);
    step(); step();
    wr(BASE, 4'b0001, 32'h0000_00F8);
    STR = 1'b0;
    check("set_wins_irq", {31'h0, IMIA_IRQ}, 32'h1);
    rd(BASE, d);     check("set_wins_tsr", d, 32'hA088F9F9);
    rd(BASE + 4, d); check("cclr_gra", d, 32'h0000_0003);

    // soft reset, then phi/8 with a 5-cycle STR pause
    soft_reset();
    rd(BASE, d);     check("res_w0", d, 32'h8088F8F8);
    rd(BASE + 4, d); check("res_w1", d, 32'h0000FFFF);
    wr(BASE, 4'b1000, 32'h0300_0000);
    stream(BASE + 4);
    for (int k = 1; k <= 23; k++) begin
      STR = (k >= 11 && k <= 15) ? 1'b0 : 1'b1;
      step();
      case (k)
        1:  check("div8_k1",  {16'h0, bus.DO[31:16]}, 32'd0);
        2:  check("div8_k2",  {16'h0, bus.DO[31:16]}, 32'd1);
        9:  check("div8_k9",  {16'h0, bus.DO[31:16]}, 32'd1);
        10: check("div8_k10", {16'h0, bus.DO[31:16]}, 32'd2);
        15: check("freeze",   {16'h0, bus.DO[31:16]}, 32'd2);
        22: check("resume22", {16'h0, bus.DO[31:16]}, 32'd2);
        23: check("resume23", {16'h0, bus.DO[31:16]}, 32'd3);
        default: ;
      endcase
    end
    STR = 1'b0;
    idle();

    // overflow from 0xFFFE, no compare clear
    soft_reset();
    wr(BASE + 4, 4'b1100, 32'hFFFE_0000);
    stream(BASE + 4);
    STR = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("ovf_seq", {16'h0, bus.DO[31:16]}, {16'h0, seq4[k]});
    end
    STR = 1'b0;
    idle();
    check("ovi_dis", {31'h0, OVI_IRQ}, 32'h0);
    wr(BASE, 4'b0010, 32'h0000_FC00);
    check("ovi_en", {30'h0, OVI_IRQ, IMIA_IRQ}, 32'h2);
    rd(BASE, d);     check("tsr_ovf", d, 32'h8088FCFF);
    wr(BASE, 4'b0001, 32'h0000_00F8);
    check("ovi_clr", {31'h0, OVI_IRQ}, 32'h0);
    rd(BASE, d);     check("tsr_clr_all", d, 32'h8088FCF8);

    // CPU TCNT write on a tick edge wins; match uses pre-write TCNT
    wr(BASE + 4, 4'b1100, 32'h0005_0000);
    wr(BASE + 8, 4'b1100, 32'h0005_0000);
    STR = 1'b1;
    wr(BASE + 4, 4'b1100, 32'h1234_0000);
    STR = 1'b0;
    rd(BASE + 4, d); check("tcnt_wr_wins", d, 32'h1234_FFFF);
    rd(BASE, d);     check("imfb_prewrite", d, 32'h8088FCFA);

    // GRA write on a tick edge: compare uses old GRA
    STR = 1'b1;
    wr(BASE + 4, 4'b0011, 32'h0000_1234);
    STR = 1'b0;
    rd(BASE, d);     check("gra_old_cmp", d, 32'h8088FCFA);
    rd(BASE + 4, d); check("gra_old_cnt", d, 32'h1235_1234);

    // reserved lanes ignored, partial TCNT write, read data held
    wr(BASE + 8, 4'b0011, 32'hFFFF_FFFF);
    rd(BASE + 8, d); check("reserved", d, 32'h0005_0000);
    wr(BASE + 4, 4'b0100, 32'h00AB_0000);
    rd(BASE + 4, d); check("partial", d, 32'h12AB_1234);
    wr(BASE + 8, 4'b1000, 32'h0000_0000);
    check("do_held", bus.DO, 32'h12AB_1234);

    // asynchronous reset mid-cycle while counting
    wr(BASE, 4'b0010, 32'h0000_FA00);
    check("imib_en", {31'h0, IMIB_IRQ}, 32'h1);
    STR = 1'b1;
    #3 RST_N = 1'b0;
    #1 check("async_irq", {29'h0, IMIA_IRQ, IMIB_IRQ, OVI_IRQ}, 32'h0);
    check("async_do", bus.DO, 32'h0);
    step();
    RST_N = 1'b1;
    STR = 1'b0;
    rd(BASE, d);     check("async_w0", d, 32'h8088F8F8);
    rd(BASE + 4, d); check("async_w1", d, 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/itu_channel.md
# itu_channel

Single 16-bit ITU timer channel for the SH7034 peripheral set: prescaled up-counter with two compare registers (GRA/GRB), overflow detect, status flags with read-then-write-0 clearing, and interrupt enables. It sits on the internal peripheral bus and drives level interrupt requests IMIA/IMIB/OVI directly into the interrupt controller's per-channel ITU inputs. Five instances (one per ITU channel) share an external start vector.

## Interface
- BASE, 28'h5FFFF04: longword-aligned address of TCR; channel occupies BASE..BASE+11.
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset.
- CE_R  in  1  rising-phase clock enable; counting and register writes.
- CE_F  in  1  falling-phase clock enable; read data capture.
- RES_N  in  1  synchronous soft reset (sampled on CE_R); same effect as RST_N on registers.
- STR  in  1  channel start (TSTR bit from shared start register); 1 = count.
- IBUS_A  in  28  byte address.
- IBUS_DI  in  32  write data, big-endian lanes.
- IBUS_DO  out  32  registered read data.
- IBUS_BA  in  4  byte enables; BA[3] = byte at offset 0 (bits 31:24).
- IBUS_WE  in  1  write strobe.
- IBUS_REQ  in  1  access request.
- IBUS_BUSY  out  1  constant 0.
- IBUS_ACT  out  1  address in BASE..BASE+11.
- IMIA_IRQ  out  1  IMFA & IMIEA.
- IMIB_IRQ  out  1  IMFB & IMIEB.
- OVI_IRQ  out  1  OVF & OVIE.

## Operation
- Register map (byte offset from BASE): 0 TCR, 1 TIOR, 2 TIER, 3 TSR, 4-5 TCNT, 6-7 GRA, 8-9 GRB, 10-11 reserved (read 0, writes ignored).
- TCR: bit7 reads 1; CCLR[6:5]: 00 no clear, 01 clear on GRA match, 10 clear on GRB match, 11 no clear; CKEG[4:3] stored only; TPSC[2:0]: 0 φ, 1 φ/2, 2 φ/4, 3 φ/8, 4-7 stopped (no external clock).
- TIOR: bits 6:4, 2:0 stored only; bits 7, 3 read 1.
- TIER: bit0 IMIEA, bit1 IMIEB, bit2 OVIE; bits 7:3 read 1.
- TSR: bit0 IMFA, bit1 IMFB, bit2 OVF; bits 7:3 read 1; write 1 has no effect.
- Flag clear: a read of TSR while flag = 1 arms that flag's clear latch; subsequent TSR write with that bit 0 clears the flag only if armed; any write to TSR disarms all latches.
- Prescaler: 3-bit counter PS increments every CE_R while STR = 1; held (not cleared) when STR = 0. Count tick when STR = 1 and TPSC valid and PS low bits for divisor are zero (φ: every CE_R; φ/8: PS = 0).
- On tick: if TCNT == GRA set IMFA; if TCNT == GRB set IMFB; if TCNT == 16'hFFFF set OVF, TCNT <= 0; else if match on CCLR-selected register TCNT <= 0; else TCNT <= TCNT + 1.
- 16-bit registers written per byte lane; partial writes allowed.
- Reset values: TCR 8'h80, TIOR 8'h88, TIER 8'hF8, TSR 8'hF8, TCNT 0, GRA 16'hFFFF, GRB 16'hFFFF, PS 0, clear latches 0, IBUS_DO 0, all IRQ outputs 0.

## Timing
- Writes take effect on the CE_R edge with IBUS_REQ & IBUS_WE & address hit.
- Reads captured into IBUS_DO on CE_F with IBUS_REQ & !IBUS_WE & hit; held until next read.
- Flags set on the CE_R of the tick; IRQ outputs combinational from registers, so valid same cycle as flag.
- Simultaneous tick and CPU write to TCNT: CPU write wins, no increment, match evaluated on pre-write value (flag still set).
- Simultaneous flag set and armed write-0 clear: set wins, flag stays 1.
- Write to GRA/GRB same cycle as tick: compare uses old value.
- STR falling mid-count: TCNT and PS freeze; resume from same values.
- RST_N asserted mid-operation: all state to reset values immediately.

## Test plan
- TPSC=0, GRA=3, CCLR=01, STR=1 -> TCNT sequence 0,1,2,3,0; IMFA set on tick at TCNT=3; IMIA_IRQ=1 only after TIER=8'hF9.
- TPSC=3, STR=1 -> TCNT increments once per 8 CE_R; STR=0 for 5 CE_R freezes TCNT and PS.
- TCNT=16'hFFFE, CCLR=00, φ -> 0xFFFF then 0x0000 with OVF=1; OVI_IRQ follows OVIE.
- IMFA=1: write TSR=8'hF8 without prior read -> IMFA stays 1; read TSR (returns 8'hF9), write 8'hF8 -> IMFA=0, IMIA_IRQ=0.
- Read TSR, then write 0 on same CE_R as a new GRA match -> IMFA remains 1.
- Longword read at BASE after reset -> IBUS_DO = 32'h8088F8F8; read at BASE+4 -> 32'h0000FFFF.
